// File: rtl/i2c_seq_pkg.sv
// Types and command flag patterns shared by the I2C register-access sequencer.
package i2c_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CMD, S_WR_PTR, S_WR_DAT, S_RP_CMD,
    S_RP_PTR, S_RD_CMD, S_RD_DAT, S_WAIT_IDLE, S_RESP
  } seq_state_e;

  typedef struct packed {
    logic [6:0] addr;
    logic       start;
    logic       read;
    logic       write;
    logic       write_multiple;
    logic       stop;
  } i2c_cmd_t;

  localparam i2c_cmd_t CMD_WR_REG = '{addr: 7'd0, start: 1'b1, read: 1'b0, write: 1'b0,
                                      write_multiple: 1'b1, stop: 1'b1};
  localparam i2c_cmd_t CMD_PTR    = '{addr: 7'd0, start: 1'b1, read: 1'b0, write: 1'b1,
                                      write_multiple: 1'b0, stop: 1'b0};
  localparam i2c_cmd_t CMD_RD     = '{addr: 7'd0, start: 1'b1, read: 1'b1, write: 1'b0,
                                      write_multiple: 1'b0, stop: 1'b1};

  function automatic i2c_cmd_t cmd_with_addr(input i2c_cmd_t flags, input logic [6:0] addr);
    i2c_cmd_t c;
    c      = flags;
    c.addr = addr;
    return c;
  endfunction

endpackage

// File: rtl/i2c_seq_wdog.sv
// Progress watchdog: counts enabled cycles since the last clear and saturates at the limit.
module i2c_seq_wdog #(
  parameter int  TIMEOUT_CYCLES = 65535,
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] r_cnt;

  assign o_expire = (r_cnt == LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_reg_seq.sv
// Sequences one register read/write request into i2c_master cmd/tx/rx traffic and one response.
// States: IDLE accept | WR_* cmd,ptr,data | RP_*/RD_* ptr write then read | WAIT_IDLE bus drain | RESP respond
module i2c_reg_seq
  import i2c_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rd,
  input  logic [6:0] i_req_dev_addr,
  input  logic [7:0] i_req_reg_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [7:0] o_rsp_rdata,
  output logic       o_rsp_err,
  output logic [6:0] o_cmd_address,
  output logic       o_cmd_start,
  output logic       o_cmd_read,
  output logic       o_cmd_write,
  output logic       o_cmd_write_multiple,
  output logic       o_cmd_stop,
  output logic       o_cmd_valid,
  input  logic       i_cmd_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  output logic       o_tx_last,
  input  logic       i_tx_ready,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_rx_last,
  output logic       o_rx_ready,
  input  logic       i_busy,
  input  logic       i_missed_ack
);

  seq_state_e r_state;
  i2c_cmd_t   r_cmd;
  logic [7:0] r_ptr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       r_err;

  logic w_active;
  logic w_hs;
  logic w_expire;
  logic w_err_nxt;

  assign o_cmd_address        = r_cmd.addr;
  assign o_cmd_start          = r_cmd.start;
  assign o_cmd_read           = r_cmd.read;
  assign o_cmd_write          = r_cmd.write;
  assign o_cmd_write_multiple = r_cmd.write_multiple;
  assign o_cmd_stop           = r_cmd.stop;

  assign w_active  = (r_state != S_IDLE) && (r_state != S_RESP);
  assign w_hs      = (o_cmd_valid && i_cmd_ready) || (o_tx_valid && i_tx_ready) ||
                     (o_rx_ready && i_rx_valid);
  assign w_err_nxt = r_err || i_missed_ack;

  i2c_seq_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    ((r_state == S_IDLE) || w_hs),
    .i_en     (w_active),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_ptr       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      o_req_ready <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_tx_data   <= '0;
      o_tx_valid  <= 1'b0;
      o_tx_last   <= 1'b0;
      o_rx_ready  <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_err   <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      if (w_active && i_missed_ack) r_err <= 1'b1;
      // Timeout abandons whatever handshake is pending; the master is left to recover on its own.
      if (w_active && w_expire) begin
        o_cmd_valid <= 1'b0;
        o_tx_valid  <= 1'b0;
        o_tx_last   <= 1'b0;
        o_rx_ready  <= 1'b0;
        r_err       <= 1'b1;
        o_rsp_valid <= 1'b1;
        o_rsp_err   <= 1'b1;
        o_rsp_rdata <= 8'h00;
        r_state     <= S_RESP;
      end else begin
        case (r_state)
          S_IDLE: begin
            o_req_ready <= 1'b1;
            if (i_req_valid && o_req_ready) begin
              o_req_ready <= 1'b0;
              r_ptr       <= i_req_reg_addr;
              r_wdata     <= i_req_wdata;
              r_rdata     <= 8'h00;
              r_err       <= 1'b0;
              o_cmd_valid <= 1'b1;
              if (i_req_rd) begin
                r_cmd   <= cmd_with_addr(CMD_PTR, i_req_dev_addr);
                r_state <= S_RP_CMD;
              end else begin
                r_cmd   <= cmd_with_addr(CMD_WR_REG, i_req_dev_addr);
                r_state <= S_WR_CMD;
              end
            end
          end
          S_WR_CMD: if (i_cmd_ready) begin
            o_cmd_valid <= 1'b0;
            o_tx_data   <= r_ptr;
            o_tx_last   <= 1'b0;
            o_tx_valid  <= 1'b1;
            r_state     <= S_WR_PTR;
          end
          S_WR_PTR: if (i_tx_ready) begin
            o_tx_data <= r_wdata;
            o_tx_last <= 1'b1;
            r_state   <= S_WR_DAT;
          end
          S_WR_DAT: if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            r_state    <= S_WAIT_IDLE;
          end
          S_RP_CMD: if (i_cmd_ready) begin
            o_cmd_valid <= 1'b0;
            o_tx_data   <= r_ptr;
            o_tx_last   <= 1'b1;
            o_tx_valid  <= 1'b1;
            r_state     <= S_RP_PTR;
          end
          S_RP_PTR: if (i_tx_ready) begin
            o_tx_valid  <= 1'b0;
            o_tx_last   <= 1'b0;
            r_cmd       <= cmd_with_addr(CMD_RD, r_cmd.addr);
            o_cmd_valid <= 1'b1;
            r_state     <= S_RD_CMD;
          end
          S_RD_CMD: if (i_cmd_ready) begin
            o_cmd_valid <= 1'b0;
            o_rx_ready  <= 1'b1;
            r_state     <= S_RD_DAT;
          end
          // A single-byte read must arrive flagged last; anything else is a framing error.
          S_RD_DAT: if (i_rx_valid) begin
            o_rx_ready <= 1'b0;
            r_rdata    <= i_rx_data;
            if (!i_rx_last) r_err <= 1'b1;
            r_state    <= S_WAIT_IDLE;
          end
          S_WAIT_IDLE: if (!i_busy) begin
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= w_err_nxt;
            o_rsp_rdata <= w_err_nxt ? 8'h00 : r_rdata;
            r_state     <= S_RESP;
          end
          S_RESP: if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_rdata <= 8'h00;
            o_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: behavioural i2c_master/slave responder plus a request-level reference model.
module tb_i2c_reg_seq;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_rd = 1'b0;
  logic [6:0] req_dev = 7'd0;
  logic [7:0] req_reg = 8'd0, req_wdata = 8'd0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [7:0] rsp_rdata;
  logic [6:0] cmd_address;
  logic       cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop, cmd_valid, cmd_ready = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_ready = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0, rx_last = 1'b0, rx_ready;
  logic       busy = 1'b0, missed_ack = 1'b0;

  always #5 clk = ~clk;

  i2c_reg_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_rd(req_rd),
    .i_req_dev_addr(req_dev), .i_req_reg_addr(req_reg), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_cmd_address(cmd_address), .o_cmd_start(cmd_start), .o_cmd_read(cmd_read),
    .o_cmd_write(cmd_write), .o_cmd_write_multiple(cmd_wm), .o_cmd_stop(cmd_stop),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .o_tx_last(tx_last), .i_tx_ready(tx_ready),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_rx_last(rx_last), .o_rx_ready(rx_ready),
    .i_busy(busy), .i_missed_ack(missed_ack)
  );

  // Environment state (written only by the responder process)
  logic [7:0]  dev_mem [2][256];
  logic [11:0] cmd_log [$];
  logic [8:0]  tx_log  [$];
  int          mutex_bad = 0;
  // Controls written only by the main sequence
  bit          stall_cmd = 1'b0, stall_rx = 1'b0, force_mack = 1'b0;
  logic [7:0]  ref_mem [2][256];
  int          n_assert = 0, n_fail = 0;

  function automatic bit present(input logic [6:0] d);
    return (d == 7'h50) || (d == 7'h51);
  endfunction

  function automatic logic [7:0] init_byte(input int dv, input int a);
    return 8'(a) ^ ((dv != 0) ? 8'h3C : 8'hA5);
  endfunction

  // Responder: acts as i2c_master + I2C memory slaves at 0x50/0x51, decides readies at negedge.
  initial begin : env
    logic [11:0] p_cmd;
    logic        p_cmd_v, p_tx_v, p_tx_last, p_rx_rdy, cur_stop, rd_pending;
    logic [7:0]  p_tx_data, ptr;
    logic [6:0]  cur_dev;
    int          byte_n, end_cnt;
    p_cmd = '0; p_cmd_v = 0; p_tx_v = 0; p_tx_last = 0; p_rx_rdy = 0; p_tx_data = '0;
    cur_stop = 0; rd_pending = 0; ptr = '0; cur_dev = '0; byte_n = 0; end_cnt = -1;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) dev_mem[d][a] = init_byte(d, a);
    forever begin
      @(negedge clk);
      missed_ack = force_mack;
      if (p_cmd_v && cmd_ready) begin
        cmd_log.push_back(p_cmd);
        cur_dev  = p_cmd[11:5];
        cur_stop = p_cmd[0];
        byte_n   = 0;
        busy     = 1'b1;
        end_cnt  = -1;
        if (!present(cur_dev)) missed_ack = 1'b1;
        if (p_cmd[3]) rd_pending = 1'b1;
      end
      if (p_tx_v && tx_ready) begin
        tx_log.push_back({p_tx_last, p_tx_data});
        if (byte_n == 0) ptr = p_tx_data;
        else if (present(cur_dev)) begin
          dev_mem[cur_dev[0]][ptr] = p_tx_data;
          ptr++;
        end
        byte_n++;
        if (p_tx_last && cur_stop) end_cnt = $urandom_range(0, 4);
      end
      if (p_rx_rdy && rx_valid) begin
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        end_cnt  = $urandom_range(0, 4);
      end
      if (rd_pending && !stall_rx && $urandom_range(0, 1) == 1) begin
        rx_data    = present(cur_dev) ? dev_mem[cur_dev[0]][ptr] : 8'hFF;
        rx_last    = 1'b1;
        rx_valid   = 1'b1;
        rd_pending = 1'b0;
      end
      if (end_cnt == 0) begin
        busy    = 1'b0;
        end_cnt = -1;
      end else if (end_cnt > 0) end_cnt--;
      if (rst) begin
        rd_pending = 0; rx_valid = 0; rx_last = 0; busy = 0; end_cnt = -1;
      end
      cmd_ready = !stall_cmd && ($urandom_range(0, 2) != 0);
      tx_ready  = ($urandom_range(0, 2) != 0);
      if (!$onehot0({cmd_valid, tx_valid, rx_ready})) mutex_bad++;
      p_cmd     = {cmd_address, cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop};
      p_cmd_v   = cmd_valid;
      p_tx_v    = tx_valid;
      p_tx_data = tx_data;
      p_tx_last = tx_last;
      p_rx_rdy  = rx_ready;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] cmd_at(input int i);
    return (i < cmd_log.size()) ? cmd_log[i] : 12'd0;
  endfunction

  function automatic logic [8:0] tx_at(input int i);
    return (i < tx_log.size()) ? tx_log[i] : 9'd0;
  endfunction

  // One full request; expected response and bus traffic come from the register-map model.
  task automatic do_req(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                        input logic [7:0] wd, input int hold, input string tag);
    int          c0, t0, n;
    bit          exp_err, stable;
    logic [7:0]  exp_rd, rd_q;
    logic        e_q;
    logic [31:0] exp_cmd;
    logic [25:0] exp_tx;
    c0 = cmd_log.size();
    t0 = tx_log.size();
    exp_err = !present(dev);
    if (!rd && !exp_err) ref_mem[dev[0]][ra] = wd;
    exp_rd  = (rd && !exp_err) ? ref_mem[dev[0]][ra] : 8'h00;
    exp_cmd = rd ? {8'd2, dev, 5'b10100, dev, 5'b11001} : {8'd1, dev, 5'b10011, 12'd0};
    exp_tx  = rd ? {8'd1, 1'b1, ra, 9'd0} : {8'd2, 1'b0, ra, 1'b1, wd};
    req_rd = rd; req_dev = dev; req_reg = ra; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tick();
    req_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 500) begin tick(); n++; end
    check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
    rd_q = rsp_rdata;
    e_q = rsp_err;
    stable = 1'b1;
    repeat (hold) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd_q || rsp_err !== e_q || req_ready !== 1'b0)
        stable = 1'b0;
    end
    check({tag, "_rsp_stable"}, stable, 1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_release"}, {rsp_valid, req_ready}, 2'b01);
    check({tag, "_err"}, e_q, exp_err);
    check({tag, "_rdata"}, rd_q, exp_rd);
    check({tag, "_cmds"}, {8'(cmd_log.size() - c0), cmd_at(c0), cmd_at(c0 + 1)}, exp_cmd);
    check({tag, "_tx"}, {8'(tx_log.size() - t0), tx_at(t0), tx_at(t0 + 1)}, exp_tx);
    check({tag, "_onehot"}, mutex_bad, 0);
  endtask

  initial begin : guard
    #600000;
    $display("FAIL global_time_limit: observed simulation still running, expected finish");
    $fatal(1, "time limit reached");
  end

  initial begin : main
    int  k;
    bit  quiet;
    logic [6:0] dv;
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) ref_mem[d][a] = init_byte(d, a);

    // Reset values
    repeat (3) tick();
    check("reset_req_ready", req_ready, 1'b0);
    check("reset_outputs",
          {cmd_valid, tx_valid, tx_last, rx_ready, rsp_valid, rsp_err, rsp_rdata,
           cmd_address, cmd_start, cmd_read, cmd_write, cmd_wm, cmd_stop}, 0);
    rst = 1'b0;
    tick();
    check("req_ready_after_reset", req_ready, 1'b1);

    // Directed register accesses
    do_req(1'b0, 7'h50, 8'h12, 8'hA5, 0, "wr_50_12");
    do_req(1'b1, 7'h50, 8'h12, 8'h00, 1, "rd_50_12");
    do_req(1'b0, 7'h33, 8'h04, 8'h77, 0, "wr_absent");
    do_req(1'b1, 7'h33, 8'h04, 8'h00, 0, "rd_absent");
    do_req(1'b1, 7'h51, 8'h05, 8'h00, 0, "rd_after_err");
    do_req(1'b0, 7'h51, 8'h00, 8'h3C, 20, "rsp_hold20");

    // Randomized traffic against the register-map model
    for (int i = 0; i < 30; i++) begin
      k  = $urandom_range(0, 4);
      dv = (k < 2) ? 7'h50 : ((k < 4) ? 7'h51 : 7'h33);
      do_req(1'($urandom_range(0, 1)), dv, 8'($urandom_range(0, 7)), 8'($urandom),
             $urandom_range(0, 3), "rand");
    end

    // Watchdog with cmd_ready stuck low; missed_ack lands in the same cycle as expiry
    stall_cmd = 1'b1;
    tick();
    req_rd = 1'b0; req_dev = 7'h50; req_reg = 8'h20; req_wdata = 8'h99; req_valid = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin tick(); k++; end
    tick();
    req_valid = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 300) begin
      if (k == TO) force_mack = 1'b1;
      tick();
      k++;
    end
    force_mack = 1'b0;
    check("timeout_latency", k, TO + 1);
    check("timeout_rsp", {rsp_valid, rsp_err, rsp_rdata, cmd_valid, tx_valid, rx_ready},
          {1'b1, 1'b1, 8'h00, 3'b000});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      if (rsp_valid !== 1'b0) quiet = 1'b0;
      tick();
    end
    check("timeout_single_rsp", quiet, 1'b1);
    stall_cmd = 1'b0;
    do_req(1'b1, 7'h50, 8'h12, 8'h00, 0, "rd_after_timeout");

    // Reset while waiting for read data
    stall_rx = 1'b1;
    req_rd = 1'b1; req_dev = 7'h50; req_reg = 8'h12; req_valid = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin tick(); k++; end
    tick();
    req_valid = 1'b0;
    k = 0;
    while (rx_ready !== 1'b1 && k < 300) begin tick(); k++; end
    check("reached_rd_dat", rx_ready, 1'b1);
    rst = 1'b1;
    tick();
    check("midreset_outputs", {cmd_valid, tx_valid, rx_ready, rsp_valid, req_ready}, 5'b00000);
    tick();
    rst = 1'b0;
    stall_rx = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      tick();
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    check("midreset_no_rsp", quiet, 1'b1);
    check("midreset_req_ready", req_ready, 1'b1);
    do_req(1'b0, 7'h50, 8'h40, 8'h5A, 0, "wr_after_reset");
    do_req(1'b1, 7'h50, 8'h40, 8'h00, 0, "rd_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
